// File: rtl/hes_pkg.sv
// Shared types for the HES cipher front end: FSM states, the FIFO entry layout
// and the byte width.
package hes_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM
    } fsm_state_t;

    typedef struct packed {
        logic              is_ct;
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/hes_sync_fifo.sv
// Single-clock show-ahead FIFO. Pushes are ignored while full and pops while
// empty. DEPTH must be a power of two so the pointers wrap on their own.
module hes_sync_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [9:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone say which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/hes_msg_framer.sv
// Frames buffered source bytes into cipher messages: one new_message pulse,
// then the message bytes, with registered cipher-side outputs.
module hes_msg_framer
    import hes_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_is_ct,
    output logic              new_message,
    output logic              input_valid,
    output logic              is_ciphertext,
    output logic [BYTE_W-1:0] input_data,
    output logic              len_err,
    output logic              msg_done
);

    fifo_entry_t       wr_entry, head;
    logic              fifo_full, fifo_empty, pop;
    fsm_state_t        state_q, state_d;
    logic [BYTE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              new_message_q, new_message_d;
    logic              input_valid_q, input_valid_d;
    logic              is_ct_q, is_ct_d;
    logic              len_err_q, len_err_d;
    logic              msg_done_q, msg_done_d;

    assign wr_entry = '{is_ct: s_is_ct, last: s_last, data: s_data};
    assign s_ready  = !fifo_full;

    hes_sync_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        is_ct_d       = is_ct_q;
        len_err_d     = len_err_q;
        new_message_d = 1'b0;
        input_valid_d = 1'b0;
        msg_done_d    = 1'b0;
        pop           = 1'b0;
        cnt_inc       = cnt_q + BYTE_W'(1);

        unique case (state_q)
            IDLE: begin
                is_ct_d = 1'b0;
                if (!fifo_empty) begin
                    state_d       = START;
                    new_message_d = 1'b1;
                    is_ct_d       = head.is_ct;
                    cnt_d         = '0;
                end
            end
            // A byte popped here is on the outputs while state_q is STREAM;
            // its registered msg_done then sends the FSM back to IDLE.
            START, STREAM: begin
                state_d = STREAM;
                if (msg_done_q) begin
                    state_d = IDLE;
                    is_ct_d = 1'b0;
                end else if (!fifo_empty) begin
                    pop           = 1'b1;
                    input_valid_d = 1'b1;
                    data_d        = head.data;
                    cnt_d         = cnt_inc;
                    if (head.last || cnt_inc == BYTE_W'(MAX_LEN)) begin
                        msg_done_d = 1'b1;
                        if (!head.last) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            is_ct_q       <= 1'b0;
            len_err_q     <= 1'b0;
            new_message_q <= 1'b0;
            input_valid_q <= 1'b0;
            msg_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            is_ct_q       <= is_ct_d;
            len_err_q     <= len_err_d;
            new_message_q <= new_message_d;
            input_valid_q <= input_valid_d;
            msg_done_q    <= msg_done_d;
        end
    end

    assign new_message   = new_message_q;
    assign input_valid   = input_valid_q;
    assign is_ciphertext = is_ct_q;
    assign input_data    = data_q;
    assign len_err       = len_err_q;
    assign msg_done      = msg_done_q;

endmodule

// File: tb/tb_hes_msg_framer.sv
// Directed and randomized bench for hes_msg_framer, checked against a
// message-level reference model and per-cycle activity traces.
module tb_hes_msg_framer;

    localparam int FIFO_DEPTH = 16;
    localparam int MAX_LEN    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_valid, s_ready, s_last, s_is_ct;
    logic [7:0] s_data;
    logic       new_message, input_valid, is_ciphertext, len_err, msg_done;
    logic [7:0] input_data;

    always #5 clk = ~clk;

    hes_msg_framer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_is_ct       (s_is_ct),
        .new_message   (new_message),
        .input_valid   (input_valid),
        .is_ciphertext (is_ciphertext),
        .input_data    (input_data),
        .len_err       (len_err),
        .msg_done      (msg_done)
    );

    // Expected cipher-side events: a start marker, then each byte of the message.
    typedef struct {
        bit       start;
        bit       is_ct;
        bit [7:0] data;
        bit       done;
        bit       err;
    } ev_t;

    ev_t   exp_q[$];
    ev_t   mon_e;
    bit    m_in_msg, m_ct, m_err, saw_full;
    int    m_len, acc_cnt, pop_cnt;
    int    n_cmp = 0;
    int    n_err = 0;
    string trace;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_trace(input string tag, input string exp_s);
        string got;
        int    n;
        n = 0;
        while (trace.len() < exp_s.len() && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = trace.substr(0, exp_s.len() - 1);
        n_cmp++;
        assert (got == exp_s) else begin
            n_err++;
            $error("FAIL %s: observed %s expected %s", tag, got, exp_s);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_in_msg = 1'b0;
        m_len    = 0;
        m_ct     = 1'b0;
        m_err    = 1'b0;
        acc_cnt  = 0;
        pop_cnt  = 0;
    endfunction

    // Message rules: mode from the first byte; a message ends on last or at MAX_LEN.
    function automatic void model_accept(input logic [7:0] d, input logic l, input logic ct);
        ev_t e;
        if (!m_in_msg) begin
            e.start = 1'b1; e.is_ct = ct; e.data = 8'h00; e.done = 1'b0; e.err = 1'b0;
            exp_q.push_back(e);
            m_in_msg = 1'b1;
            m_len    = 0;
            m_ct     = ct;
        end
        m_len++;
        if (m_len == MAX_LEN && !l) m_err = 1'b1;
        e.start = 1'b0; e.is_ct = m_ct; e.data = d;
        e.done  = l || (m_len == MAX_LEN);
        e.err   = m_err;
        exp_q.push_back(e);
        if (e.done) m_in_msg = 1'b0;
        acc_cnt++;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic ct);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_is_ct = ct;
        while (!s_ready && waited < 100) begin
            saw_full = 1'b1;
            check("full_occupancy", 32'(acc_cnt - pop_cnt), 32'(FIFO_DEPTH));
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(s_ready), 32'd1);
        if (s_ready) model_accept(d, l, ct);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    // Monitor: one sample per cycle, just after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (new_message && input_valid) trace = {trace, "X"};
            else if (new_message)           trace = {trace, "N"};
            else if (input_valid)           trace = {trace, "D"};
            else                            trace = {trace, "-"};
            check("exclusive", 32'(new_message && input_valid), 32'd0);
            if (new_message || input_valid) begin
                check("event_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.start)
                        check("start", {28'd0, new_message, input_valid, is_ciphertext, msg_done},
                              {28'd0, 1'b1, 1'b0, mon_e.is_ct, 1'b0});
                    else
                        check("byte", {19'd0, new_message, input_valid, is_ciphertext, input_data,
                                       msg_done, len_err},
                              {19'd0, 1'b0, 1'b1, mon_e.is_ct, mon_e.data, mon_e.done, mon_e.err});
                end
                if (input_valid) pop_cnt++;
            end else begin
                check("quiet_done", 32'(msg_done), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] d;
        int         len;

        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_is_ct = 1'b0;
        saw_full = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        idle(3);
        check("rst_outputs", {19'd0, new_message, input_valid, is_ciphertext, input_data, msg_done,
                              len_err}, 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        idle(2);
        check("idle_s_ready", 32'(s_ready), 32'd1);

        // Single plaintext message.
        trace = "";
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        check_trace("single_trace", "-NDDD-");
        wait_drain();

        // Back-to-back: ciphertext pair then plaintext pair.
        trace = "";
        send(8'($urandom), 1'b0, 1'b1);
        send(8'($urandom), 1'b1, 1'b1);
        send(8'($urandom), 1'b0, 1'b0);
        send(8'($urandom), 1'b1, 1'b0);
        check_trace("b2b_trace", "-NDD-NDD-");
        wait_drain();

        // Underrun: four idle source edges leave the cipher three bubble cycles.
        trace = "";
        send(8'($urandom), 1'b0, 1'b0);
        send(8'($urandom), 1'b0, 1'b0);
        idle(4);
        send(8'($urandom), 1'b0, 1'b0);
        send(8'($urandom), 1'b1, 1'b0);
        check_trace("underrun_trace", "-NDD---DD-");
        wait_drain();

        // Over-length: six bytes with MAX_LEN of four split into 4 + 2.
        trace = "";
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'(i == 5), 1'b1);
        check_trace("overlen_trace", "-NDDDD-NDD-");
        wait_drain();
        check("len_err_set", 32'(len_err), 32'(m_err));

        // Backpressure: single-byte messages drain at one per three cycles.
        saw_full = 1'b0;
        for (int i = 0; i < 30; i++) send(8'($urandom), 1'b1, 1'($urandom));
        check("saw_full", 32'(saw_full), 32'd1);
        wait_drain();
        check("len_err_sticky", 32'(len_err), 32'd1);

        // Reset after two bytes of a message are out.
        trace = "";
        for (int i = 0; i < 4; i++) send(8'(8'h50 + i), 1'b0, 1'b1);
        check_trace("pre_reset_trace", "-NDD");
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {19'd0, new_message, input_valid, is_ciphertext, input_data, msg_done,
                                 len_err}, 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        trace = "";
        send(8'h77, 1'b0, 1'b1);
        send(8'h78, 1'b1, 1'b1);
        check_trace("post_reset_trace", "-NDD-");
        wait_drain();

        // Random messages, random per-byte mode, random source gaps.
        for (int m = 0; m < 12; m++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom);
                send(d, 1'(i == len - 1), 1'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_drain();
        check("final_len_err", 32'(len_err), 32'(m_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hes_msg_framer.md
# hes_msg_framer

Upstream framing stage for the HES byte-stream cipher. Accepts plaintext or ciphertext bytes from a valid/ready source with an end-of-message marker, buffers them in a small FIFO, and drives the cipher's `new_message`, `input_valid`, `is_ciphertext` and `input_data` inputs. It pulses `new_message` once per message before that message's first byte, so the keystream counter always restarts at the key.

## Interface
- `FIFO_DEPTH`, 16: entries in the input FIFO; power of two, at least 2.
- `MAX_LEN`, 255: maximum bytes per message, 1..255. A longer message is force-terminated.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  source byte valid.
- `s_ready`  out  1  framer can accept a byte.
- `s_data`  in  8  source byte.
- `s_last`  in  1  byte is the last of its message.
- `s_is_ct`  in  1  message is ciphertext; sampled on every byte, used from the first byte only.
- `new_message`  out  1  one-cycle keystream restart pulse.
- `input_valid`  out  1  `input_data` is valid this cycle.
- `is_ciphertext`  out  1  mode of the current message.
- `input_data`  out  8  byte to the cipher.
- `len_err`  out  1  sticky flag; set when a message exceeds `MAX_LEN`.
- `msg_done`  out  1  one-cycle pulse with the final byte of each message.

## Operation
- A byte is accepted on a clock edge where `s_valid && s_ready`. `s_ready = !fifo_full`, combinational from the FIFO count.
- There is no push while full, even if a pop occurs in the same cycle.
- Each FIFO entry holds {is_ct, last, data}, 10 bits.
- FSM states are IDLE, START and STREAM.
  - IDLE: all cipher outputs low. If the FIFO is non-empty, go to START.
  - START: drive `new_message=1`, `input_valid=0`, and `is_ciphertext` = head.is_ct. Clear the byte counter. Go to STREAM. No pop in this state.
  - STREAM, FIFO non-empty: pop the head. Drive `input_valid=1` and `input_data` = head.data. Increment the byte counter (8 bits). Hold `is_ciphertext` at its START value.
    - If head.last, or the counter reaches `MAX_LEN`: assert `msg_done` and go to IDLE.
    - On the `MAX_LEN` termination without head.last, also set `len_err`. The remaining bytes of that message then form a new message.
  - STREAM, FIFO empty: drive `input_valid=0` (a bubble) and stay in STREAM. No `new_message` is issued.
- `new_message` and `input_valid` are never high in the same cycle.
- Consecutive messages are separated by exactly two non-data cycles: IDLE, then START.
- `len_err` is cleared only by reset.

## Timing
- All cipher-side outputs and `msg_done` are registered.
- Reset values:
  - `new_message`, `input_valid`, `is_ciphertext`, `msg_done`, `len_err` = 0; `input_data` = 8'h00.
  - FSM in IDLE, FIFO empty, so `s_ready` = 1 during and after reset.
- Latency, with the FIFO empty and the FSM in IDLE:
  - byte accepted at edge E0;
  - `new_message` high in the cycle after E1;
  - that byte appears on `input_valid`/`input_data` in the cycle after E2.
- Steady-state throughput is one byte per cycle within a message.
- Reset asserted mid-message: the FIFO is flushed, the FSM goes to IDLE, and all outputs take their reset values immediately (asynchronously). The partially sent message is not resumed.
- Simultaneous push and pop when not full: both occur, and the count is unchanged.

## Structure
- `hes_pkg` holds:
  - `fsm_state_t` enum {IDLE, START, STREAM};
  - `fifo_entry_t` packed struct {is_ct, last, data[7:0]};
  - a localparam for the 8-bit byte width.
- Sub-module `hes_sync_fifo`, parameterised on depth and entry type:
  - single clock, asynchronous active-low reset;
  - outputs `full`, `empty` and show-ahead head data;
  - count width `$clog2(DEPTH+1)`.
- The FSM, byte counter and output registers live in `hes_msg_framer`.

## Test plan
- **Single message:** bytes 8'h11, 8'h22, 8'h33 (last on 8'h33), `s_is_ct=0`.
  - Response: one `new_message` pulse, then `input_valid` for exactly 3 consecutive cycles with data 11, 22, 33.
  - `msg_done` with 8'h33; `is_ciphertext`=0 throughout.
- **Back-to-back messages:** 2 bytes with `s_is_ct=1`, immediately followed by 2 bytes with `s_is_ct=0`.
  - Response: two `new_message` pulses, each followed by 2 data cycles.
  - `is_ciphertext` = 1, then 0; exactly 2 non-data cycles between the messages.
- **Backpressure:** push 20 bytes with no pops possible while the FIFO fills (`FIFO_DEPTH`=16).
  - Response: `s_ready` drops after 16 accepted entries; no byte is lost or duplicated.
  - Output order equals input order.
- **Underrun:** the source pauses 3 cycles mid-message.
  - Response: 3 bubble cycles with `input_valid=0`, no extra `new_message`, and the message completes correctly.
- **Over-length:** `MAX_LEN`=4, 6-byte message.
  - Response: `msg_done` after byte 4 with `len_err` set.
  - A new `new_message` precedes bytes 5 and 6.
- **Reset mid-message:** assert `rst_n`=0 after 2 of 5 bytes have been output.
  - Response: all outputs go to their reset values and `s_ready`=1.
  - A subsequent message starts cleanly with `new_message`.
